// File: rtl/demux_1x8_rr_sched.sv
// demux_1x8_rr_sched: round-robin scheduler fanning one valid/ready stream out to
// 8 sinks through a one-entry holding register. Disabled channels are skipped
// when a grant is chosen.
// Optional feature macro: DEMUX_SCHED_TIMEOUT_EN. When it is defined, a word that
// is held for TIMEOUT cycles without delivery is dropped, and drop pulses for one
// cycle. When it is undefined, words are held indefinitely and drop stays 0.
module demux_1x8_rr_sched #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [7:0]    chan_en,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [7:0]    out_ready,
  output logic [2:0]    sel,
  output logic          busy,
  output logic          drop
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  // Marker scope that flags out-of-range TIMEOUT values at elaboration.
  if (TIMEOUT < 1) begin : g_bad_timeout
  end

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [7:0]    valid_q, valid_d;
  logic          drop_q, drop_d;

  logic          deliver_s;
  logic          accept_s;
  logic          timeout_s;
  logic [2:0]    grant_s;

  // First enabled channel after p, scanning p+1 .. p+8 modulo 8.
  // If no channel is enabled, p itself is returned; that grant is never
  // used because in_ready is low whenever the mask is empty.
  function automatic logic [2:0] next_grant(input logic [2:0] p, input logic [7:0] en);
    logic [2:0] idx;
    logic       found;
    next_grant = p;
    found      = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = p + 3'(i);
      if (!found && en[idx]) begin
        next_grant = idx;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Handshake terms. Only out_ready of the granted sink matters.
  assign deliver_s = (state_q == ST_FULL) && out_ready[sel_q];
  assign in_ready  = (|chan_en) && ((state_q == ST_EMPTY) || deliver_s);
  assign accept_s  = in_valid && in_ready;
  assign grant_s   = next_grant(ptr_q, chan_en);

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // A stall expires on the last held cycle unless the word is delivered in that cycle.
  assign timeout_s = (state_q == ST_FULL) && !deliver_s && (cnt_q == CW'(TIMEOUT - 1));

  // Hold counter: cleared on every load, advanced on every stalled FULL cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = {CW{1'b0}};
    end else if ((state_q == ST_FULL) && !deliver_s) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register, together with the holding register and the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= {DW{1'b0}};
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      valid_q <= 8'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: fill on accept; empty on deliver or expiry; otherwise keep the word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else if (deliver_s || timeout_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Datapath: load the new grant on accept. Clearing out_valid leaves sel and ptr
  // unchanged, so the next grant starts scanning after the last granted channel.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    drop_d  = timeout_s;
    if (accept_s) begin
      data_d  = in_data;
      sel_d   = grant_s;
      ptr_d   = grant_s;
      valid_d = 8'd1 << grant_s;
    end else if (deliver_s || timeout_s) begin
      valid_d = 8'd0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = (state_q == ST_FULL);
  assign drop      = drop_q;

endmodule
